// File: rtl/tinyalu_core.sv
// TinyALU datapath: one command per start/done handshake.
// add/and/xor complete one clock after capture; mul completes MUL_LAT clocks after capture.
module tinyalu_core #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 done,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(MUL_LAT + 1);

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        WAIT_LOW
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]      op_q;
    logic [CW-1:0]   count;
    logic [RW-1:0]   alu_c;
    logic [RW-1:0]   prod_c;

    // Single-cycle ops, zero-extended to the full result width
    always_comb begin
        alu_c = '0;
        case (op_q)
            OP_ADD:  alu_c = RW'(a_q) + RW'(b_q);
            OP_AND:  alu_c = RW'(a_q & b_q);
            OP_XOR:  alu_c = RW'(a_q ^ b_q);
            default: alu_c = '0;
        endcase
    end

    assign prod_c = RW'(a_q) * RW'(b_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            done   <= 1'b0;
            busy   <= 1'b0;
            result <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_ADD || op == OP_AND || op == OP_XOR) begin
                            a_q   <= A;
                            b_q   <= B;
                            op_q  <= op;
                            busy  <= 1'b1;
                            state <= EXEC;
                        end else if (op == OP_MUL) begin
                            a_q   <= A;
                            b_q   <= B;
                            op_q  <= op;
                            count <= CW'(1);
                            busy  <= 1'b1;
                            state <= MUL;
                        end
                    end
                end
                EXEC: begin
                    result <= alu_c;
                    done   <= 1'b1;
                    state  <= WAIT_LOW;
                end
                MUL: begin
                    // count tracks clocks since capture; finish on the MUL_LAT-th edge
                    if (count == CW'(MUL_LAT)) begin
                        result <= prod_c;
                        done   <= 1'b1;
                        state  <= WAIT_LOW;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                WAIT_LOW: begin
                    busy <= 1'b0;
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_core.sv
// Randomized self-checking bench for tinyalu_core against an arithmetic reference model.
module tb_tinyalu_core;

    localparam int unsigned W  = 8;
    localparam int unsigned ML = 3;

    logic           clk;
    logic           reset;
    logic           start;
    logic [2:0]     op;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           done;
    logic           busy;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_result;

    tinyalu_core #(.WIDTH(W), .MUL_LAT(ML)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .done   (done),
        .busy   (busy),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain unsigned arithmetic, truncated to the 16-bit result
    function automatic logic [15:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int unsigned ia = a;
        int unsigned ib = b;
        case (o)
            3'd1:    return 16'(ia + ib);
            3'd2:    return 16'(ia & ib);
            3'd3:    return 16'(ia ^ ib);
            3'd4:    return 16'(ia * ib);
            default: return 16'(0);
        endcase
    endfunction

    function automatic logic [7:0] biased_operand();
        int r = $urandom_range(0, 3);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one valid command, verify latency/result, optionally hold or drop start
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input int hold, input bit drop);
        logic [15:0] exp;
        int lat;
        int n;
        exp = model(o, a, b);
        lat = (o == 3'd4) ? int'(ML) : 1;
        start = 1'b1; op = o; A = a; B = b;
        tick();
        check("busy_capture", 32'(busy), 32'(1));
        A = 8'($urandom); B = 8'($urandom); op = 3'($urandom);
        if (drop) start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'(lat));
        check("result", 32'(result), 32'(exp));
        check("busy_done", 32'(busy), 32'(1));
        last_result = exp;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("single_done", 32'(done), 32'(0));
            check("busy_hold", 32'(busy), 32'(0));
        end
        start = 1'b0;
        tick();
        check("done_after", 32'(done), 32'(0));
        check("busy_after", 32'(busy), 32'(0));
        check("result_hold", 32'(result), 32'(last_result));
    endtask

    // Hold an unsupported op with start high; nothing may happen
    task automatic run_invalid(input logic [2:0] o, input int cycles);
        start = 1'b1; op = o; A = 8'($urandom); B = 8'($urandom);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check("inv_done", 32'(done), 32'(0));
            check("inv_busy", 32'(busy), 32'(0));
            check("inv_result", 32'(result), 32'(last_result));
        end
        start = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0;
        last_result = 16'h0000;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_done", 32'(done), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_result", 32'(result), 32'(0));
        end
        reset = 1'b0;
        tick();

        run_op(3'd1, 8'hFF, 8'hFF, 0, 1'b0);
        check("add_ff_ff", 32'(result), 32'h01FE);
        run_op(3'd2, 8'hF0, 8'h3C, 0, 1'b0);
        check("and_f0_3c", 32'(result), 32'h0030);
        run_op(3'd3, 8'hAA, 8'hFF, 0, 1'b0);
        check("xor_aa_ff", 32'(result), 32'h0055);
        run_op(3'd4, 8'hFF, 8'hFF, 0, 1'b0);
        check("mul_ff_ff", 32'(result), 32'hFE01);
        run_op(3'd4, 8'h00, 8'h80, 0, 1'b0);
        check("mul_00_80", 32'(result), 32'h0000);
        run_op(3'd1, 8'h12, 8'h34, 0, 1'b0);

        run_invalid(3'd0, 5);
        run_invalid(3'd6, 5);
        run_invalid(3'd5, 2);
        run_invalid(3'd7, 2);

        run_op(3'd4, 8'h10, 8'h10, 4, 1'b0);
        run_op(3'd4, 8'h03, 8'h05, 0, 1'b0);
        run_op(3'd1, 8'h80, 8'h80, 0, 1'b1);
        run_op(3'd4, 8'h7F, 8'h02, 0, 1'b1);

        // Reset one clock after a mul capture aborts it
        start = 1'b1; op = 3'd4; A = 8'hFF; B = 8'hFF;
        tick();
        check("abort_busy_cap", 32'(busy), 32'(1));
        reset = 1'b1; start = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_result", 32'(result), 32'(0));
        reset = 1'b0;
        last_result = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_done", 32'(done), 32'(0));
        end
        run_op(3'd1, 8'h01, 8'h02, 0, 1'b0);
        check("post_abort_add", 32'(result), 32'h0003);

        for (int k = 0; k < 1000; k++) begin
            int sel;
            int hold;
            logic [2:0] o;
            sel = $urandom_range(0, 9);
            if (sel == 9) begin
                o = (($urandom & 1) != 0) ? 3'd0 : 3'(3'd5 + 3'($urandom_range(0, 2)));
                run_invalid(o, $urandom_range(1, 3));
            end else begin
                o = 3'($urandom_range(1, 4));
                hold = $urandom_range(0, 2);
                run_op(o, biased_operand(), biased_operand(), hold,
                       (hold == 0) && (($urandom & 1) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
